// File: rtl/lifo_drain_ctrl_if.sv
// lifo_drain_ctrl_if
// Bundles the control, upstream-LIFO and downstream-stream signals of
// lifo_drain_ctrl so they travel as one port.
//   start/count       : drain request and its word count (0 = until empty)
//   lifo_empty/dout   : upstream LIFO status and read data
//   lifo_pop          : pop strobe back to the LIFO
//   out_data/valid    : registered drained word offered downstream
//   out_ready         : downstream acceptance
//   busy/done/drained : drain status
// Modports: master = environment around the controller, slave = controller.
interface lifo_drain_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             start;
  logic [CW-1:0]    count;
  logic             lifo_empty;
  logic [WIDTH-1:0] lifo_dout;
  logic             lifo_pop;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [CW-1:0]    drained;

  modport master (
    output start, count, lifo_empty, lifo_dout, out_ready,
    input  lifo_pop, out_data, out_valid, busy, done, drained
  );

  modport slave (
    input  start, count, lifo_empty, lifo_dout, out_ready,
    output lifo_pop, out_data, out_valid, busy, done, drained
  );
endinterface

// File: rtl/lifo_drain_ctrl.sv
// lifo_drain_ctrl
// Pops words from an upstream LIFO one at a time and hands each to a
// valid/ready consumer. A drain moves either a fixed number of words
// (count != 0, clamped to DEPTH) or runs until the LIFO reports empty
// (count == 0). One word takes POP -> CAPT -> HOLD, i.e. three cycles with
// out_ready held high.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : lifo_drain_ctrl_if.slave (see interface header)
module lifo_drain_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  lifo_drain_ctrl_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, POP, CAPT, HOLD, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    remaining_reg, remaining_next;
  logic             all_mode_reg, all_mode_next;   // count was 0: drain until empty
  logic [CW-1:0]    drained_reg, drained_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             pop;

  logic [CW-1:0]    count_clamped;
  logic             stop;

  assign count_clamped = (bus.count > DEPTH_CW) ? DEPTH_CW : bus.count;
  // Empty is only consulted here, so words pushed mid-drain are still picked up.
  assign stop = bus.lifo_empty || (!all_mode_reg && (remaining_reg == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      all_mode_reg  <= 1'b0;
      drained_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      all_mode_reg  <= all_mode_next;
      drained_reg   <= drained_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    all_mode_next  = all_mode_reg;
    drained_next   = drained_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    pop            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          remaining_next = count_clamped;
          all_mode_next  = (bus.count == '0);
          drained_next   = '0;
          state_next     = POP;
        end
      end
      POP: begin
        if (stop) begin
          state_next = DONE;
        end else begin
          pop        = 1'b1;
          state_next = CAPT;
        end
      end
      CAPT: begin
        // LIFO read data is valid the cycle after the pop.
        out_data_next  = bus.lifo_dout;
        out_valid_next = 1'b1;
        state_next     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          if (drained_reg != DEPTH_CW) begin
            drained_next = drained_reg + CW'(1);
          end
          if (!all_mode_reg) begin
            remaining_next = remaining_reg - CW'(1);
          end
          state_next = POP;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.lifo_pop  = pop;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.drained   = drained_reg;
endmodule

// File: tb/tb_lifo_drain_ctrl.sv
module tb_lifo_drain_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lifo_drain_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

  lifo_drain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // Upstream LIFO model
  logic [WIDTH-1:0] stack [0:15];
  int               sp = 0;
  logic [WIDTH-1:0] lifo_dout_reg = '0;
  logic             push_en, lifo_clr;
  logic [WIDTH-1:0] push_val;

  assign bus_if.lifo_empty = (sp == 0);
  assign bus_if.lifo_dout  = lifo_dout_reg;

  always @(posedge clk) begin
    if (lifo_clr) begin
      sp <= 0;
    end else if (bus_if.lifo_pop && sp != 0) begin
      lifo_dout_reg <= stack[sp-1];
      sp            <= sp - 1;
    end else if (push_en) begin
      stack[sp] <= push_val;
      sp        <= sp + 1;
    end
  end

  // Monitor
  logic [WIDTH-1:0] rx [0:127];
  int rx_n = 0, pop_total = 0, pop_bad = 0, done_total = 0, done_bad = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (bus_if.lifo_pop) begin
      pop_total <= pop_total + 1;
      if (bus_if.lifo_empty) pop_bad <= pop_bad + 1;
    end
    if (bus_if.out_valid && bus_if.out_ready && !reset) begin
      rx[rx_n] <= bus_if.out_data;
      rx_n     <= rx_n + 1;
      $display("RX word %02h drained=%0d t=%0t", bus_if.out_data, bus_if.drained, $time);
    end
    if (bus_if.done) begin
      done_total <= done_total + 1;
      if (done_prev) done_bad <= done_bad + 1;
    end
    done_prev <= bus_if.done;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    push_en  = 1'b1;
    push_val = v;
    tick();
    push_en  = 1'b0;
  endtask

  task automatic clear_lifo();
    lifo_clr = 1'b1;
    tick();
    lifo_clr = 1'b0;
  endtask

  task automatic start_drain(input logic [CW-1:0] c);
    bus_if.start = 1'b1;
    bus_if.count = c;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (bus_if.done) break;
      n++;
    end
    if (n >= 300) check("done_timeout", 1, 0);
    tick();
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (bus_if.out_valid) break;
      k++;
    end
    if (k >= 50) check("valid_timeout", 1, 0);
  endtask

  int n, rb, pb, db;

  initial begin
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.count = '0;
    bus_if.out_ready = 1'b1;
    push_en = 1'b0;
    push_val = '0;
    lifo_clr = 1'b0;
    repeat (3) tick();
    check("rst_busy", bus_if.busy, 0);
    check("rst_valid", bus_if.out_valid, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_drained", bus_if.drained, 0);
    check("rst_pop", bus_if.lifo_pop, 0);
    check("rst_data", bus_if.out_data, 0);
    reset = 1'b0;
    tick();

    // Scenario 1: count=2 from 01,02,03
    push(8'h01); push(8'h02); push(8'h03);
    rb = rx_n; pb = pop_total; db = done_total;
    start_drain(2);
    wait_done(n);
    check("s1_w0", rx[rb], 8'h03);
    check("s1_w1", rx[rb+1], 8'h02);
    check("s1_pops", pop_total - pb, 2);
    check("s1_done", done_total - db, 1);
    check("s1_drained", bus_if.drained, 2);
    check("s1_left", sp, 1);
    check("s1_top", stack[0], 8'h01);
    check("s1_busy", bus_if.busy, 0);
    clear_lifo();

    // Scenario 2: empty LIFO, count=0
    pb = pop_total;
    start_drain(0);
    @(negedge clk);
    check("s2_busy", bus_if.busy, 1);
    check("s2_early_done", bus_if.done, 0);
    check("s2_no_pop", bus_if.lifo_pop, 0);
    @(negedge clk);
    check("s2_done", bus_if.done, 1);
    tick();
    check("s2_drained", bus_if.drained, 0);
    check("s2_pops", pop_total - pb, 0);

    // Scenario 3: 5 words, count=0, 3-cycle throughput
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    rb = rx_n; pb = pop_total;
    start_drain(0);
    wait_done(n);
    check("s3_cycles", n, 16);
    for (int i = 0; i < 5; i++) check("s3_word", rx[rb+i], 8'(8'h15 - i));
    check("s3_drained", bus_if.drained, 5);
    check("s3_pops", pop_total - pb, 5);

    // Scenario 4: backpressure in HOLD
    push(8'h21); push(8'h22);
    bus_if.out_ready = 1'b0;
    rb = rx_n; pb = pop_total;
    start_drain(2);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s4_valid_hold", bus_if.out_valid, 1);
      check("s4_data_hold", bus_if.out_data, 8'h22);
    end
    #1;
    check("s4_stall_pops", pop_total - pb, 1);
    tick();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s4_resume_pop", bus_if.lifo_pop, 1);
    wait_done(n);
    check("s4_w0", rx[rb], 8'h22);
    check("s4_w1", rx[rb+1], 8'h21);
    check("s4_drained", bus_if.drained, 2);

    // Scenario 5: start while busy is ignored
    push(8'h31); push(8'h32); push(8'h33);
    rb = rx_n; pb = pop_total; db = done_total;
    start_drain(2);
    tick(); tick();
    start_drain(7);
    wait_done(n);
    repeat (4) tick();
    check("s5_pops", pop_total - pb, 2);
    check("s5_drained", bus_if.drained, 2);
    check("s5_w0", rx[rb], 8'h33);
    check("s5_w1", rx[rb+1], 8'h32);
    check("s5_done", done_total - db, 1);
    check("s5_left", sp, 1);
    check("s5_idle", bus_if.busy, 0);
    clear_lifo();

    // count above DEPTH clamps; drained saturates at DEPTH
    for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
    pb = pop_total;
    start_drain(12);
    wait_done(n);
    check("clamp_pops", pop_total - pb, 8);
    check("clamp_drained", bus_if.drained, 8);
    check("clamp_left", sp, 2);
    clear_lifo();
    for (int i = 0; i < 10; i++) push(8'(8'h60 + i));
    pb = pop_total;
    start_drain(0);
    wait_done(n);
    check("sat_pops", pop_total - pb, 10);
    check("sat_drained", bus_if.drained, 8);

    // Scenario 6: reset during HOLD
    push(8'h41); push(8'h42); push(8'h43);
    bus_if.out_ready = 1'b0;
    db = done_total;
    start_drain(3);
    wait_valid();
    tick();
    reset = 1'b1;
    tick();
    check("s6_busy", bus_if.busy, 0);
    check("s6_valid", bus_if.out_valid, 0);
    check("s6_data", bus_if.out_data, 0);
    check("s6_drained", bus_if.drained, 0);
    check("s6_done", bus_if.done, 0);
    check("s6_pop", bus_if.lifo_pop, 0);
    reset = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (3) tick();
    check("s6_no_done", done_total - db, 0);
    rb = rx_n;
    start_drain(0);
    wait_done(n);
    check("s6_w0", rx[rb], 8'h42);
    check("s6_w1", rx[rb+1], 8'h41);
    check("s6_fresh_drained", bus_if.drained, 2);
    check("s6_fresh_done", done_total - db, 1);

    check("pop_while_empty", pop_bad, 0);
    check("done_width", done_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
